// File: rtl/gctr_function_n_blocks_masked_if.sv
// Word bus of the masked multi-lane GCTR datapath: plaintext lanes, valid mask
// and message framing in; ciphertext lanes and delayed framing out.
// Optional macro GCTR_BYTE_MASK_EN adds i_last_nbytes (byte count of the
// highest valid lane on the eop word).
interface gctr_function_n_blocks_masked_if #(
    parameter int N_BLOCKS = 4
);
    localparam int NB_DATA = N_BLOCKS * 128;

    logic [NB_DATA-1:0]  i_plaintext_words_x;
    logic [N_BLOCKS-1:0] i_block_mask;
    logic                i_sop;
    logic                i_eop;
    logic                i_valid;
`ifdef GCTR_BYTE_MASK_EN
    logic [3:0]          i_last_nbytes;
`endif
    logic [NB_DATA-1:0]  o_ciphertext_words_y;
    logic [N_BLOCKS-1:0] o_block_mask;
    logic                o_sop;
    logic                o_eop;
    logic                o_valid;

    modport slave (
`ifdef GCTR_BYTE_MASK_EN
        input  i_last_nbytes,
`endif
        input  i_plaintext_words_x, i_block_mask, i_sop, i_eop, i_valid,
        output o_ciphertext_words_y, o_block_mask, o_sop, o_eop, o_valid
    );

    modport master (
`ifdef GCTR_BYTE_MASK_EN
        output i_last_nbytes,
`endif
        output i_plaintext_words_x, i_block_mask, i_sop, i_eop, i_valid,
        input  o_ciphertext_words_y, o_block_mask, o_sop, o_eop, o_valid
    );
endinterface

// File: rtl/gctr_function_n_blocks_masked.sv
// AES-256 counter-mode datapath, N_BLOCKS lanes per word with a per-lane valid
// mask, selectable counter increment width and per-message block limit.
// Pipeline: one counter stage, then a 15-stage round ladder (AddRoundKey 0,
// rounds 1..14), so a word appears LATENCY edges after the accepting edge.
// Optional macro GCTR_BYTE_MASK_EN: truncates the last lane of the eop word
// to i_last_nbytes bytes (0 means 16).
module gctr_function_n_blocks_masked #(
    parameter int NB_BLOCK    = 128,
    parameter int N_ROUNDS    = 14,
    parameter int N_BLOCKS    = 4,
    parameter int NB_DATA     = N_BLOCKS * NB_BLOCK,
    parameter int NB_INC_MODE = 2,
    parameter int LATENCY     = 15,
    parameter int NB_BLK_CNT  = 36,
    parameter logic [NB_BLK_CNT-1:0] MAX_BLOCKS = NB_BLK_CNT'(64'd4294967294)
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    gctr_function_n_blocks_masked_if.slave   bus,
    input  logic [NB_BLOCK*(N_ROUNDS+1)-1:0] i_round_key_vector,
    input  logic [NB_BLOCK-1:0]              i_initial_counter_block,
    input  logic [NB_INC_MODE-1:0]           i_rf_static_inc_mode,
    output logic                             o_mask_err,
    output logic                             o_overflow
);
    generate
        if (NB_BLOCK != 128 || N_ROUNDS != 14) begin : g_bad_aes
            $error("only AES-256 with 128-bit blocks is supported");
        end
        if (N_BLOCKS < 1 || N_BLOCKS > 8) begin : g_bad_lanes
            $error("N_BLOCKS must be 1..8");
        end
        if (NB_DATA != N_BLOCKS * NB_BLOCK || LATENCY != N_ROUNDS + 1) begin : g_bad_geom
            $error("NB_DATA/LATENCY inconsistent with lane count and rounds");
        end
    endgenerate

    typedef struct packed {
        logic                valid;
        logic                sop;
        logic                eop;
        logic [N_BLOCKS-1:0] mask;
        logic [N_BLOCKS-1:0] eff;
        logic                ovf;
`ifdef GCTR_BYTE_MASK_EN
        logic [3:0]          nv;
        logic [3:0]          nbytes;
`endif
    } sb_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127, v;
        x3   = gmul(gmul(a, a), a);
        x7   = gmul(gmul(x3, x3), a);
        x15  = gmul(gmul(x7, x7), a);
        x31  = gmul(gmul(x15, x15), a);
        x63  = gmul(gmul(x31, x31), a);
        x127 = gmul(gmul(x63, x63), a);
        v    = gmul(x127, x127);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // One AES round; byte i of the state is bits [127-8i -: 8], column-major.
    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic mix);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            if (mix) begin
                o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end else begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end
        end
        return o ^ rk;
    endfunction

    // Adds n to the low 32/64/96/128 bits; carries out of that field are dropped.
    function automatic logic [127:0] inc(input logic [127:0] x, input logic [3:0] n,
                                         input logic [NB_INC_MODE-1:0] m);
        case (int'(m))
            0:       return {x[127:32], x[31:0] + 32'(n)};
            1:       return {x[127:64], x[63:0] + 64'(n)};
            2:       return {x[127:96], x[95:0] + 96'(n)};
            default: return x + 128'(n);
        endcase
    endfunction

    function automatic logic [3:0] run_len(input logic [N_BLOCKS-1:0] m);
        logic [3:0] n;
        logic       stop;
        n = '0;
        stop = 1'b0;
        for (int k = 0; k < N_BLOCKS; k++) begin
            if (!stop && m[k]) n = n + 4'd1;
            else stop = 1'b1;
        end
        return n;
    endfunction

`ifdef GCTR_BYTE_MASK_EN
    function automatic logic [127:0] byte_keep(input logic eop, input logic [3:0] nv,
                                               input logic [3:0] nbytes, input int k);
        if (eop && nv != 4'd0 && 4'(k) == nv - 4'd1 && nbytes != 4'd0)
            return ~({128{1'b1}} >> {nbytes, 3'b000});
        return {128{1'b1}};
    endfunction
`endif

    logic [127:0]          ctr_next_q;
    logic [NB_BLK_CNT-1:0] blk_cnt_q;
    logic                  mask_err_q, overflow_q;
    sb_t                   sb_q [LATENCY+1];
    logic [127:0]          ctr_q [N_BLOCKS];
    logic [127:0]          pt_q  [LATENCY][N_BLOCKS];
    logic [127:0]          st_q  [N_ROUNDS][N_BLOCKS];
    logic [NB_DATA-1:0]    ct_q;

    logic [3:0]            nv_d;
    logic [N_BLOCKS-1:0]   eff_d;
    logic [127:0]          base_d;
    logic [NB_BLK_CNT:0]   cnt_sum_d;
    logic [NB_BLK_CNT-1:0] cnt_d;
    sb_t                   sb_d;

    // Acceptance decode: valid-lane run, base counter, block count and sideband.
    always_comb begin
        nv_d  = run_len(bus.i_block_mask);
        eff_d = '0;
        for (int k = 0; k < N_BLOCKS; k++) eff_d[k] = (4'(k) < nv_d);
        base_d    = bus.i_sop ? i_initial_counter_block : ctr_next_q;
        cnt_sum_d = {1'b0, (bus.i_sop ? {NB_BLK_CNT{1'b0}} : blk_cnt_q)}
                    + (NB_BLK_CNT+1)'(nv_d);
        cnt_d     = cnt_sum_d[NB_BLK_CNT] ? {NB_BLK_CNT{1'b1}} : cnt_sum_d[NB_BLK_CNT-1:0];
        sb_d = '0;
        if (bus.i_valid) begin
            sb_d.valid = 1'b1;
            sb_d.sop   = bus.i_sop;
            sb_d.eop   = bus.i_eop;
            sb_d.mask  = bus.i_block_mask;
            sb_d.eff   = eff_d;
            sb_d.ovf   = (cnt_d > MAX_BLOCKS);
`ifdef GCTR_BYTE_MASK_EN
            sb_d.nv     = nv_d;
            sb_d.nbytes = bus.i_last_nbytes;
`endif
        end
    end

    // Control state: next counter, block count, sideband delay line, status flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ctr_next_q <= '0;
            blk_cnt_q  <= '0;
            mask_err_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i <= LATENCY; i++) sb_q[i] <= '0;
        end else begin
            mask_err_q <= bus.i_valid && (bus.i_block_mask != eff_d);
            if (bus.i_valid) begin
                ctr_next_q <= inc(base_d, nv_d, i_rf_static_inc_mode);
                blk_cnt_q  <= cnt_d;
            end
            sb_q[0] <= sb_d;
            for (int i = 1; i <= LATENCY; i++) sb_q[i] <= sb_q[i-1];
            if (sb_q[LATENCY-1].valid) begin
                if (sb_q[LATENCY-1].sop)     overflow_q <= sb_q[LATENCY-1].ovf;
                else if (sb_q[LATENCY-1].ovf) overflow_q <= 1'b1;
            end
        end
    end

    // Datapath: lane counters, round ladder, keystream XOR and lane gating.
    always_ff @(posedge i_clock) begin
        for (int k = 0; k < N_BLOCKS; k++) begin
            ctr_q[k]    <= inc(base_d, 4'(k), i_rf_static_inc_mode);
            pt_q[0][k]  <= bus.i_plaintext_words_x[k*128 +: 128];
            st_q[0][k]  <= ctr_q[k] ^ i_round_key_vector[127:0];
            for (int r = 1; r < N_ROUNDS; r++)
                st_q[r][k] <= aes_round(st_q[r-1][k], i_round_key_vector[r*128 +: 128], 1'b1);
            for (int j = 1; j < LATENCY; j++) pt_q[j][k] <= pt_q[j-1][k];
            ct_q[k*128 +: 128] <=
                (aes_round(st_q[N_ROUNDS-1][k], i_round_key_vector[N_ROUNDS*128 +: 128], 1'b0)
                 ^ pt_q[LATENCY-1][k])
                & {128{sb_q[LATENCY-1].eff[k]}}
`ifdef GCTR_BYTE_MASK_EN
                & byte_keep(sb_q[LATENCY-1].eop, sb_q[LATENCY-1].nv,
                            sb_q[LATENCY-1].nbytes, k)
`endif
                ;
        end
    end

    assign bus.o_ciphertext_words_y = sb_q[LATENCY].valid ? ct_q : '0;
    assign bus.o_block_mask         = sb_q[LATENCY].mask;
    assign bus.o_sop                = sb_q[LATENCY].sop;
    assign bus.o_eop                = sb_q[LATENCY].eop;
    assign bus.o_valid              = sb_q[LATENCY].valid;
    assign o_mask_err               = mask_err_q;
    assign o_overflow               = overflow_q;
endmodule

// File: doc/gctr_function_n_blocks_masked.md
Name: gctr_function_n_blocks_masked

Overview:
Parametrised successor of the fixed-width GCTR datapath. It encrypts up to N_BLOCKS 128-bit blocks per cycle in AES-256 counter mode, and supports these cases:
- partial words, via a per-block valid mask;
- selectable counter increment width;
- a sideband delay line that carries SOP/EOP/mask alongside the AES pipeline;
- enforcement of the GCM per-message block limit.

It sits between the key-expansion block and the GHASH stage of the GCM core.

Parameters:
NB_BLOCK, 128, block width (only 128 legal)
N_ROUNDS, 14, AES rounds (only 14 legal)
N_BLOCKS, 4, parallel block lanes (1..8)
NB_DATA, N_BLOCKS*NB_BLOCK, data bus width
NB_INC_MODE, 2, increment-mode select width
LATENCY, 15, cycles of the per-lane AES round ladder; sets the sideband delay length
NB_BLK_CNT, 36, width of the per-message block counter
MAX_BLOCKS, 2^32-2, legal blocks per message

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_plaintext_words_x  in  NB_DATA  plaintext; lane k at bits [k*128 +: 128]
i_block_mask  in  N_BLOCKS  valid lanes; LSB-first thermometer
i_round_key_vector  in  128*(N_ROUNDS+1)  expanded key
i_initial_counter_block  in  128  J0-derived initial counter
i_rf_static_inc_mode  in  NB_INC_MODE  increment field: 0=32b, 1=64b, 2=96b, 3=128b
i_sop  in  1  first word of message; qualified by i_valid
i_eop  in  1  last word of message; qualified by i_valid
i_valid  in  1  input word valid
o_ciphertext_words_y  out  NB_DATA  ciphertext
o_block_mask  out  N_BLOCKS  delayed i_block_mask
o_sop  out  1  delayed i_sop
o_eop  out  1  delayed i_eop
o_valid  out  1  output word valid
o_mask_err  out  1  one-cycle pulse; non-thermometer mask accepted
o_overflow  out  1  sticky; message exceeded MAX_BLOCKS

Behaviour:
- Reset values: all outputs 0; counter register, block counter and delay line all cleared.
- Accepted word: i_valid=1. Words with i_valid=0 have no effect. i_sop/i_eop/i_block_mask are ignored when i_valid=0.
- Base counter per word:
  - i_sop=1: base = i_initial_counter_block.
  - otherwise: base = stored next-counter register.
- Lane k counter = inc(base, k). The stored register updates to inc(base, V), where V = number of valid lanes.
- inc(x, n): adds n modulo 2^W to the low W bits (W = 32/64/96/128 per mode); upper bits unchanged. Wrap-around is silent.
- Mask rules:
  - Legal masks are thermometer codes, e.g. 0001, 0011, 0111, 1111.
  - A non-thermometer mask pulses o_mask_err at acceptance. V is then the length of the contiguous run from bit 0; higher set bits are treated as invalid.
  - All-zero mask with i_valid=1 is legal: V=0, counter holds, word propagates.
- Latency: o_valid, o_sop, o_eop and o_block_mask appear exactly LATENCY cycles after the accepting edge. Throughput is 1 word/cycle with no backpressure.
- Data gating: output lanes with o_block_mask bit 0 are forced to 0. When o_valid=0, o_ciphertext_words_y = 0.
- Block counter:
  - i_sop loads V; otherwise it adds V. It saturates at all-ones.
  - o_overflow sets, on the output word carrying the first block beyond MAX_BLOCKS, once the count exceeds MAX_BLOCKS.
  - o_overflow clears when the next o_sop is emitted. That o_sop word is itself evaluated against the new count.
- i_sop and i_eop on the same word: single-word message; both flags propagate.
- i_sop mid-message (no prior eop): restarts the counter; no error.
- Reset mid-operation: in-flight words are discarded and o_valid stays 0 until new words traverse the pipeline. The round-key input is not sampled by reset.
- Configuration checks:
  - NB_BLOCK!=128 or N_ROUNDS!=14 fails elaboration.
  - N_BLOCKS>8 fails elaboration.

Optional Feature:
GCTR_BYTE_MASK_EN:
- Defined: adds input port i_last_nbytes (4 bits; 0 means 16). This is a byte count for the highest valid lane of the eop word. It is delayed with the sideband. On o_eop, bytes of that lane beyond the count are forced to 0; byte 0 is the MSB byte [127:120].
- Undefined: port absent; full blocks are always output.

Test Plan:
1. Reset, then i_sop=1, mask=1111, mode=0, J0 low32=0x00000002 -> lane counters 0x2,0x3,0x4,0x5; next counter 0x6; o_valid exactly LATENCY=15 cycles later; ciphertext matches the C model.
2. Mode 0, J0 low32=0xFFFFFFFE, mask=1111 -> lane counters 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 with upper 96 bits unchanged. Mode 1, same J0 -> carry into bit 32.
3. Words with masks 1111, 0011, 0000, 0001 -> counters advance by 4, 2, 0, 1; output lanes with mask bit 0 read 0; mask 0101 -> o_mask_err pulse and V=1.
4. i_valid toggled 1,0,0,1 with i_eop on the 2nd accepted word -> o_valid pattern identical but shifted 15 cycles; o_eop aligned to the 2nd output word.
5. Block counter preset near the limit (test hook forces count to 2^32-4): accept 4 blocks -> o_overflow rises on that output word; stays high until the next o_sop.
6. i_reset asserted while 10 words are in flight -> no o_valid in the following 15 cycles; the first post-reset i_sop restarts from J0. With GCTR_BYTE_MASK_EN: eop word, mask=0001, i_last_nbytes=5 -> bytes 5..15 of lane 0 are 0.
